// File: rtl/cpu_avm_count_master.sv
// Periodic Avalon-MM writer of an incrementing count; optional readback check under CPU_AVM_READBACK_CHECK_EN.
// Latency: write strobe the cycle after a tick, 2 cycles tick->DONE (3 with readback); waitrequest holds each bus phase.
// Backpressure: one tick arriving while busy is queued as pending, a further one sets sticky overrun and is dropped.
module cpu_avm_count_master #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PERIOD   = 50000000,
    parameter logic [1:0]  TGT_ADDR = 2'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] count,
    output logic              busy,
    output logic              overrun,
    output logic              mismatch
);

    localparam int unsigned   PW         = $clog2(PERIOD);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PERIOD - 1);

`ifdef CPU_AVM_READBACK_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_presc;
    logic [DATA_W-1:0] r_count;
    logic              r_pending;
    logic              r_overrun;
    logic              w_tick;
    logic              w_start;
    logic              w_unused_rd;

    // Tick fires in the last prescaler cycle, i.e. on the edge that wraps it to 0.
    assign w_tick = enable && (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (enable) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

`ifdef CPU_AVM_READBACK_CHECK_EN
    logic w_rd_accept;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
`ifdef CPU_AVM_READBACK_CHECK_EN
        w_rd_accept = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_tick || r_pending) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
`ifdef CPU_AVM_READBACK_CHECK_EN
                    w_state_nxt = S_READ;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef CPU_AVM_READBACK_CHECK_EN
            S_READ: begin
                if (!avm_waitrequest) begin
                    w_rd_accept = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs decode only from registered state/count, so they cannot move during a stall.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_read_n     = 1'b1;
        avm_address    = 2'd0;
        avm_writedata  = 32'd0;
        case (r_state)
            S_WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = TGT_ADDR;
                avm_writedata  = 32'(r_count);
            end
`ifdef CPU_AVM_READBACK_CHECK_EN
            S_READ: begin
                avm_chipselect = 1'b1;
                avm_read_n     = 1'b0;
                avm_address    = TGT_ADDR;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_count   <= r_count + DATA_W'(1);
                r_pending <= 1'b0;
            end else if (w_tick && (r_state != S_IDLE)) begin
                // Only one tick can be queued; a second one while queued is lost.
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

`ifdef CPU_AVM_READBACK_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_rd_accept && (avm_readdata[DATA_W-1:0] != r_count)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign w_unused_rd = ^avm_readdata;
    assign count       = r_count;
    assign busy        = (r_state != S_IDLE);
    assign overrun     = r_overrun;

endmodule
